// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM decoder: FSM state encoding and
// the glitch-filter length used when PWM_DECODER_GLITCH_FILTER_EN is defined.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_state_t;

    // Consecutive identical samples required before the filtered level moves
    localparam int FILTER_LEN = 3;

endpackage

// File: rtl/pwm_edge_detect.sv
// Synchronizes pwm_in and produces one-cycle rise/fall pulses.
// Optional majority-free run-length filter enabled by PWM_DECODER_GLITCH_FILTER_EN.
module pwm_edge_detect
    import pwm_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic pwm_in,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_reg;
    logic       sample;
    logic       level_reg;
    logic       rise_reg;
    logic       fall_reg;

    assign sample = sync_reg[1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[0], pwm_in};
        end
    end

`ifdef PWM_DECODER_GLITCH_FILTER_EN
    // Last FILTER_LEN-1 samples; together with the current one they form the run
    logic [FILTER_LEN-2:0] hist_reg;
    logic                  all_high;
    logic                  all_low;

    assign all_high = sample & (&hist_reg);
    assign all_low  = ~sample & ~(|hist_reg);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist_reg  <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            hist_reg <= (hist_reg << 1) | (FILTER_LEN-1)'(sample);
            rise_reg <= all_high & ~level_reg;
            fall_reg <= all_low & level_reg;
            if (all_high) begin
                level_reg <= 1'b1;
            end else if (all_low) begin
                level_reg <= 1'b0;
            end
        end
    end
`else
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            level_reg <= sample;
            rise_reg  <= sample & ~level_reg;
            fall_reg  <= ~sample & level_reg;
        end
    end
`endif

    assign rise = rise_reg;
    assign fall = fall_reg;

endmodule

// File: rtl/pwm_decoder.sv
// Measures PWM high time and period in clock cycles; valid pulses per full period.
// Define PWM_DECODER_GLITCH_FILTER_EN to reject input pulses shorter than 3 cycles.
module pwm_decoder
    import pwm_pkg::*;
#(
    parameter int n_bit = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [n_bit-1:0] high_count,
    output logic [n_bit-1:0] period_count,
    output logic             valid,
    output logic             overflow
);

    localparam logic [n_bit-1:0] CNT_MAX = '1;

    pwm_state_t       state_reg;
    pwm_state_t       state_next;
    logic [n_bit-1:0] cnt_reg;
    logic [n_bit-1:0] cnt_next;
    logic [n_bit-1:0] high_reg;
    logic [n_bit-1:0] high_next;
    logic [n_bit-1:0] period_reg;
    logic [n_bit-1:0] period_next;
    logic             valid_reg;
    logic             valid_next;
    logic             overflow_reg;
    logic             overflow_next;
    logic             rise;
    logic             fall;

    pwm_edge_detect u_edge_detect (
        .clock  (clock),
        .reset  (reset),
        .pwm_in (pwm_in),
        .rise   (rise),
        .fall   (fall)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            high_reg     <= '0;
            period_reg   <= '0;
            valid_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            high_reg     <= high_next;
            period_reg   <= period_next;
            valid_reg    <= valid_next;
            overflow_reg <= overflow_next;
        end
    end

    // cnt starts at 1 on the rise cycle so both widths come out exact
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        high_next     = high_reg;
        period_next   = period_reg;
        valid_next    = 1'b0;
        overflow_next = 1'b0;
        if (!enable) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (rise) begin
                        state_next = HIGH;
                        cnt_next   = n_bit'(1);
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_next = LOW;
                        high_next  = cnt_reg;
                        cnt_next   = cnt_reg + n_bit'(1);
                    end else if (cnt_reg == CNT_MAX) begin
                        state_next    = IDLE;
                        cnt_next      = '0;
                        overflow_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + n_bit'(1);
                    end
                end
                LOW: begin
                    if (rise) begin
                        state_next  = HIGH;
                        period_next = cnt_reg;
                        cnt_next    = n_bit'(1);
                        valid_next  = 1'b1;
                    end else if (cnt_reg == CNT_MAX) begin
                        state_next    = IDLE;
                        cnt_next      = '0;
                        overflow_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + n_bit'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    assign high_count   = high_reg;
    assign period_count = period_reg;
    assign valid        = valid_reg;
    assign overflow     = overflow_reg;

endmodule

// File: tb/tb_pwm_decoder.sv
// Scoreboard bench for pwm_decoder: expected (high, period) pairs are queued at
// each closing rise and compared when valid pulses.
module tb_pwm_decoder;
    import pwm_pkg::*;

    localparam int N_BIT = 8;

    typedef struct packed {
        logic [15:0] h;
        logic [15:0] p;
    } exp_t;

    logic             clock;
    logic             reset;
    logic             enable;
    logic             pwm_in;
    logic [N_BIT-1:0] high_count;
    logic [N_BIT-1:0] period_count;
    logic             valid;
    logic             overflow;

    exp_t sb[$];
    exp_t mon_e;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   ovf_count    = 0;
    bit   have_start   = 0;
    int   cur_h        = 0;
    int   cur_p        = 0;
    int   last_h       = 0;
    int   last_p       = 0;

    pwm_decoder #(.n_bit(N_BIT)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .pwm_in       (pwm_in),
        .high_count   (high_count),
        .period_count (period_count),
        .valid        (valid),
        .overflow     (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input int observed, input int expected);
        tests_run++;
        if (observed != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Rising edge of pwm_in; it closes the previous period if one is open
    task automatic start_high();
        exp_t e;
        pwm_in = 1'b1;
        if (have_start) begin
            e.h = 16'(cur_h);
            e.p = 16'(cur_p);
            sb.push_back(e);
            last_h = cur_h;
            last_p = cur_p;
        end
        have_start = 1'b1;
    endtask

    task automatic pulse(input int h, input int l);
        start_high();
        cycles(h);
        pwm_in = 1'b0;
        cycles(l);
        cur_h = h;
        cur_p = h + l;
    endtask

    // Park the DUT in IDLE so idle gaps between scenarios cannot be measured
    task automatic quiesce();
        enable = 1'b0;
        cycles(4);
        enable = 1'b1;
        have_start = 1'b0;
        cycles(12);
        check_value("sb_drained", sb.size(), 0);
    endtask

    always @(negedge clock) begin
        if (valid) begin
            $display("[TB] valid high_count=%0d period_count=%0d", high_count, period_count);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check_value("high_count", int'(high_count), int'(mon_e.h));
                check_value("period_count", int'(period_count), int'(mon_e.p));
            end else begin
                check_value("unexpected_valid", int'(valid), 0);
            end
        end
        if (overflow) ovf_count++;
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        pwm_in = 1'b0;
        cycles(3);
        check_value("rst_high", int'(high_count), 0);
        check_value("rst_period", int'(period_count), 0);
        check_value("rst_valid", int'(valid), 0);
        check_value("rst_overflow", int'(overflow), 0);
        reset = 1'b0;
        cycles(2);
        enable = 1'b1;
        cycles(2);

        // Square wave 3 high / 5 low
        repeat (5) pulse(3, 5);
        quiesce();

        // Duty sweep extreme: period exactly at counter maximum
`ifdef PWM_DECODER_GLITCH_FILTER_EN
        repeat (3) pulse(3, 252);
`else
        repeat (3) pulse(1, 254);
`endif
        quiesce();
        check_value("sweep_no_overflow", ovf_count, 0);

        // Stuck high: saturate in HIGH
        ovf_count = 0;
        start_high();
        cycles(300);
        check_value("ovf_pulses", ovf_count, 1);
        check_value("ovf_state", int'(dut.state_reg), int'(IDLE));
        check_value("ovf_high_kept", int'(high_count), last_h);
        check_value("ovf_period_kept", int'(period_count), last_p);
        pwm_in = 1'b0;
        cycles(10);
        quiesce();
        check_value("ovf_once", ovf_count, 1);

        // Enable dropped mid-LOW
        repeat (2) pulse(3, 5);
        start_high();
        cycles(3);
        pwm_in = 1'b0;
        cycles(7);
        enable = 1'b0;
        cycles(2);
        enable = 1'b1;
        have_start = 1'b0;
        cycles(1);
        repeat (3) pulse(3, 5);
        quiesce();

        // Reset in the middle of a HIGH phase
        repeat (2) pulse(3, 5);
        start_high();
        cycles(8);
        reset = 1'b1;
        #1;
        check_value("mid_rst_high", int'(high_count), 0);
        check_value("mid_rst_period", int'(period_count), 0);
        check_value("mid_rst_valid", int'(valid), 0);
        check_value("mid_rst_overflow", int'(overflow), 0);
        pwm_in = 1'b0;
        cycles(3);
        reset = 1'b0;
        have_start = 1'b0;
        cycles(2);
        repeat (3) pulse(3, 5);
        quiesce();
        check_value("post_rst_high", int'(high_count), 3);
        check_value("post_rst_period", int'(period_count), 8);

        // One-cycle glitch inside the LOW phase
        pulse(3, 5);
`ifdef PWM_DECODER_GLITCH_FILTER_EN
        start_high();
        cycles(3);
        pwm_in = 1'b0;
        cycles(3);
        pwm_in = 1'b1;
        cycles(1);
        pwm_in = 1'b0;
        cycles(1);
        cur_h = 3;
        cur_p = 8;
`else
        pulse(3, 3);
        pulse(1, 1);
`endif
        repeat (2) pulse(3, 5);
        quiesce();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pwm_decoder.md
PWM_DECODER -- requirements
Module: pwm_decoder

Interface
REQ-001 The module SHALL have parameter: n_bit, 8, width of measurement counters and outputs.
REQ-002 The module SHALL have port: clock  input  1  rising-edge system clock.
REQ-003 The module SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 The module SHALL have port: enable  input  1  measurement enable, level-sensitive.
REQ-005 The module SHALL have port: pwm_in  input  1  PWM signal, asynchronous to clock.
REQ-006 The module SHALL have port: high_count  output  n_bit  last measured high time, in clock cycles.
REQ-007 The module SHALL have port: period_count  output  n_bit  last measured period, in clock cycles.
REQ-008 The module SHALL have port: valid  output  1  one-cycle pulse when high_count/period_count update as a pair.
REQ-009 The module SHALL have port: overflow  output  1  one-cycle pulse on measurement counter saturation.

Function
REQ-010 pwm_in SHALL pass through a 2-flop synchronizer; rise/fall SHALL be detected by comparing synchronized sample with its registered previous value.
REQ-011 States SHALL be IDLE, HIGH, LOW.
REQ-012 IDLE->HIGH on detected rise with enable=1; cnt<=1; no capture, no valid.
REQ-013 HIGH->LOW on detected fall; high_count<=cnt; cnt<=cnt+1.
REQ-014 LOW->HIGH on detected rise; period_count<=cnt; cnt<=1; valid=1 in the following cycle, coincident with the new period_count.
REQ-015 In HIGH/LOW without an edge, cnt SHALL increment by 1 per cycle.
REQ-016 Resulting semantics: high_count = cycles from rise to fall, period_count = cycles from rise to next rise, both exact.
REQ-017 If cnt equals 2^n_bit-1 in HIGH or LOW with no edge, next state SHALL be IDLE, with overflow pulsed one cycle; high_count/period_count retained.
REQ-018 enable=0 SHALL force IDLE the next cycle from any state; no valid; outputs retained.
REQ-019 Falls and rises SHALL be ignored in IDLE when enable=0; fall in IDLE always ignored.
REQ-020 valid SHALL pulse only after a complete HIGH->LOW->HIGH sequence; a rise directly following a HIGH period with no detected fall cannot occur and needs no handling.
REQ-021 Edge-to-state latency SHALL be 3 cycles from pwm_in change (2 sync + 1 edge register); measured widths SHALL be unaffected by this latency.

Reset
REQ-022 reset SHALL asynchronously set state=IDLE, cnt=0, high_count=0, period_count=0, valid=0, overflow=0, synchronizer flops=0.
REQ-023 reset mid-measurement SHALL discard the partial measurement; first valid after reset requires two further rises.

Configuration
REQ-024 With PWM_DECODER_GLITCH_FILTER_EN defined, the synchronized sample SHALL change the filtered level only after 3 consecutive identical samples, adding 2 cycles of edge latency; pulses shorter than 3 cycles SHALL be ignored.
REQ-025 Without PWM_DECODER_GLITCH_FILTER_EN, no filter SHALL exist; every synchronized transition is an edge.

Structure
REQ-026 Package pwm_pkg SHALL hold the state enum typedef (IDLE, HIGH, LOW) and the filter length constant (3).
REQ-027 Synchronizer, optional filter and edge detection SHALL be sub-module pwm_edge_detect (outputs rise, fall).

Verification
REQ-028 Square wave with high 3 cycles, low 5 cycles, enable=1 -> after second rise valid pulses, high_count=3, period_count=8; repeats each period.
REQ-029 Duty sweep: high 1, low 254 (n_bit=8), without filter -> high_count=1, period_count=255, no overflow.
REQ-030 pwm_in held high 300 cycles after first rise -> overflow pulses once at cnt=255, state IDLE, no valid, outputs unchanged.
REQ-031 enable dropped mid-LOW, raised again -> no valid until two further rises; then correct values.
REQ-032 reset asserted mid-HIGH -> all outputs 0 immediately; next valid only after two rises.
REQ-033 1-cycle glitch in LOW phase: with filter -> ignored, period_count=8; without filter -> period split, valid with shortened period.
